// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing the registered ALU datapath: load, execute, write, respond.
// Define ALU_SEQ_PERF_CNT_EN to build the perf_ops / perf_busy counters; otherwise they read 0.
module alu_sequencer #(
   parameter int MUL_CYCLES = 2,
   parameter int DIV_CYCLES = 8,
   parameter int CNT_W      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic        req_imm,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_err,
   output logic        ldA,
   output logic        ldB,
   output logic        clrA,
   output logic        clrB,
   output logic        clrResult,
   output logic        ldResult,
   output logic        isImmediate,
   output logic [2:0]  aluSel,
   output logic [12:0] op_en,
   output logic        wrFlag,
   output logic [31:0] perf_ops,
   output logic [31:0] perf_busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [3:0] OP_CMP = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4;
   localparam logic [3:0] OP_MOD = 4'd5;
   localparam logic [3:0] OP_MAX = 4'd12;

   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic             imm_q, imm_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counter preload: last EXEC cycle index for the latched operation.
   function automatic logic [CNT_W-1:0] exec_last(input logic [3:0] op);
      logic [CNT_W-1:0] n;
      case (op)
         OP_MUL:         n = MUL_LAST;
         OP_DIV, OP_MOD: n = DIV_LAST;
         default:        n = '0;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] unit_sel(input logic [3:0] op);
      logic [2:0] sel;
      case (op)
         4'd0, 4'd1, 4'd2: sel = 3'd0;
         4'd3:             sel = 3'd1;
         4'd4, 4'd5:       sel = 3'd2;
         4'd12:            sel = 3'd3;
         4'd9, 4'd10, 4'd11: sel = 3'd4;
         4'd6, 4'd7, 4'd8: sel = 3'd5;
         default:          sel = 3'd0;
      endcase
      return sel;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         imm_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         imm_q   <= imm_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      imm_d   = imm_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d  = req_op;
               imm_d = req_imm;
               err_d = (req_op > OP_MAX);
               state_d = (req_op > OP_MAX) ? S_RESP : S_LOAD;
            end
         end
         S_LOAD: begin
            cnt_d   = exec_last(op_q);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (cnt_q == '0) state_d = S_WRITE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced quiet while rst is high so an aborted op never strobes the datapath.
   always_comb begin
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      ldA         = 1'b0;
      ldB         = 1'b0;
      ldResult    = 1'b0;
      wrFlag      = 1'b0;
      isImmediate = 1'b0;
      aluSel      = 3'd0;
      op_en       = '0;
      if (!rst) begin
         case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_LOAD, S_EXEC, S_WRITE: begin
               isImmediate = imm_q;
               aluSel      = unit_sel(op_q);
               op_en       = 13'b1 << op_q;
               if (state_q == S_LOAD) begin
                  ldA = 1'b1;
                  ldB = 1'b1;
               end
               if (state_q == S_WRITE) begin
                  if (op_q == OP_CMP) wrFlag   = 1'b1;
                  else                ldResult = 1'b1;
               end
            end
            S_RESP: begin
               rsp_valid = 1'b1;
               rsp_err   = err_q;
            end
            default: ;
         endcase
      end
   end

   assign clrA      = rst;
   assign clrB      = rst;
   assign clrResult = rst;

`ifdef ALU_SEQ_PERF_CNT_EN
   logic [31:0] perf_ops_q, perf_ops_d;
   logic [31:0] perf_busy_q, perf_busy_d;

   always_comb begin
      perf_ops_d  = perf_ops_q + ((rsp_valid && rsp_ready) ? 32'd1 : 32'd0);
      perf_busy_d = perf_busy_q + ((state_q != S_IDLE) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_q  <= '0;
         perf_busy_q <= '0;
      end else begin
         perf_ops_q  <= perf_ops_d;
         perf_busy_q <= perf_busy_d;
      end
   end

   assign perf_ops  = perf_ops_q;
   assign perf_busy = perf_busy_q;
`else
   assign perf_ops  = '0;
   assign perf_busy = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer; expected per-cycle strobes come from an op timeline model.
module tb_alu_sequencer;

   localparam int MUL_N = 2;
   localparam int DIV_N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic        req_imm = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic        rsp_err;
   logic        ldA, ldB, clrA, clrB, clrResult, ldResult, isImmediate, wrFlag;
   logic [2:0]  aluSel;
   logic [12:0] op_en;
   logic [31:0] perf_ops, perf_busy;

   int total = 0;
   int bad = 0;
   int unsigned exp_ops = 0;
   int unsigned exp_busy = 0;
   int unit_tbl [13] = '{0, 0, 0, 1, 2, 2, 5, 5, 5, 4, 4, 4, 3};

   alu_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_imm(req_imm),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err),
      .ldA(ldA), .ldB(ldB), .clrA(clrA), .clrB(clrB), .clrResult(clrResult),
      .ldResult(ldResult), .isImmediate(isImmediate), .aluSel(aluSel), .op_en(op_en),
      .wrFlag(wrFlag), .perf_ops(perf_ops), .perf_busy(perf_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int n_of(input int op);
      if (op == 3) return MUL_N;
      if (op == 4 || op == 5) return DIV_N;
      return 1;
   endfunction

   // Caller is at a negedge with the DUT idle; returns at the negedge of the next idle cycle.
   task automatic run_op(input int op, input bit imm, input int stall);
      bit illegal;
      int n, rs, last;
      bit act, ld, wr_cycle;
      logic [12:0] en;
      logic [2:0] sel;
      illegal = (op > 12);
      n = n_of(op);
      rs = illegal ? 1 : n + 3;
      last = rs + stall + 1;
      chk($sformatf("op%0d_accept_ready", op), 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op = op[3:0];
      req_imm = imm;
      rsp_ready = 1'($urandom);
      @(posedge clk);
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         req_valid = 1'($urandom);
         req_op = 4'($urandom);
         req_imm = 1'($urandom);
         rsp_ready = (k < rs) ? 1'($urandom) : (k >= rs + stall);
         act = !illegal && k >= 1 && k <= n + 2;
         ld = !illegal && k == 1;
         wr_cycle = !illegal && k == n + 2;
         en = act ? (13'b1 << op) : 13'b0;
         sel = act ? 3'(unit_tbl[illegal ? 0 : op]) : 3'd0;
         chk($sformatf("op%0d_k%0d_strobes", op, k),
             32'({ldA, ldB, ldResult, wrFlag, clrA, clrB, clrResult}),
             32'({ld, ld, wr_cycle && op != 2, wr_cycle && op == 2, 3'b000}));
         chk($sformatf("op%0d_k%0d_select", op, k),
             32'({isImmediate, aluSel, op_en}), 32'({act && imm, sel, en}));
         chk($sformatf("op%0d_k%0d_handshake", op, k),
             32'({req_ready, rsp_valid, rsp_err}),
             32'({k == last, k >= rs && k <= rs + stall, illegal && k >= rs && k <= rs + stall}));
         if (k < last) exp_busy++;
         if (k == rs + stall) exp_ops++;
      end
   endtask

   task automatic chk_perf(input string tag);
`ifdef ALU_SEQ_PERF_CNT_EN
      chk({tag, "_perf_ops"}, perf_ops, exp_ops);
      chk({tag, "_perf_busy"}, perf_busy, exp_busy);
`else
      chk({tag, "_perf_ops"}, perf_ops, 32'd0);
      chk({tag, "_perf_busy"}, perf_busy, 32'd0);
`endif
   endtask

   initial begin
      // Power-on reset: datapath clears follow rst, controller quiet.
      repeat (3) begin
         @(negedge clk);
         chk("por_clr", 32'({clrA, clrB, clrResult}), 32'd7);
         chk("por_rsp", 32'({rsp_valid, ldResult}), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("por_idle", 32'({req_ready, rsp_valid, clrA, clrB, clrResult}), 32'h10);
      chk_perf("por");

      run_op(0, 1'b0, 0);
      run_op(4, 1'b0, 0);
      run_op(2, 1'b1, 0);
      run_op(14, 1'b0, 0);
      run_op(14, 1'b1, 2);

      // Abort a DIV mid-EXEC with a 3-cycle reset.
      chk("abort_accept_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op = 4'd4;
      req_imm = 1'b0;
      @(posedge clk);
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      exp_ops = 0;
      exp_busy = 0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         chk($sformatf("abort_rst%0d_clr", i), 32'({clrA, clrB, clrResult}), 32'd7);
         chk($sformatf("abort_rst%0d_quiet", i), 32'({ldResult, rsp_valid, wrFlag}), 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_idle", 32'({req_ready, rsp_valid, clrA, clrB, clrResult}), 32'h10);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("abort_post%0d", i), 32'({req_ready, rsp_valid, ldResult}), 32'h4);
      end

      // MUL with a stalled response, then ADD back-to-back.
      run_op(3, 1'b1, 5);
      run_op(0, 1'b0, 0);
`ifdef ALU_SEQ_PERF_CNT_EN
      chk("pair_perf_ops", perf_ops, 32'd2);
`endif
      chk_perf("pair");

      for (int t = 0; t < 30; t++) begin
         run_op(int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk("final_idle", 32'({req_ready, rsp_valid}), 32'h2);
      chk_perf("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the registered ALU datapath (operand registers A/B, result register, flag write).
- Accepts one operation per transaction over a valid/ready request channel.
- Drives load, clear, unit-enable and select strobes in order.
- Returns completion over a valid/ready response channel.
- Sits between instruction decode/issue and the ALU; one operation in flight at a time.

Parameters:
MUL_CYCLES, 2, EXEC cycles held for MUL (min 1)
DIV_CYCLES, 8, EXEC cycles held for DIV/MOD (min 1)
CNT_W, 8, width of internal EXEC cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  operation request
req_ready  out  1  sequencer can accept
req_op  in  4  opcode: 0 ADD, 1 SUB, 2 CMP, 3 MUL, 4 DIV, 5 MOD, 6 LSL, 7 LSR, 8 ASR, 9 OR, 10 NOT, 11 AND, 12 MOV, 13-15 illegal
req_imm  in  1  B operand comes from immediate
rsp_valid  out  1  operation complete
rsp_ready  in  1  consumer accepts response
rsp_err  out  1  illegal opcode, valid with rsp_valid
ldA, ldB  out  1  load operand registers
clrA, clrB, clrResult  out  1  clear datapath registers
ldResult  out  1  load result register
isImmediate  out  1  B-mux select
aluSel  out  3  unit select: 0 adder (ADD/SUB/CMP), 1 mul, 2 div (DIV/MOD), 3 mov, 4 logic (OR/NOT/AND), 5 shift
op_en  out  13  one-hot unit enable; bit i = opcode i
wrFlag  out  1  flag register write strobe
perf_ops  out  32  completed-op counter (optional feature)
perf_busy  out  32  non-IDLE cycle counter (optional feature)

Behaviour:
- Reset:
  - state=IDLE.
  - All strobes, op_en, aluSel, rsp_* = 0.
  - clrA/clrB/clrResult = rst (combinational), so datapath clears with the controller.
  - rst mid-operation aborts; no response is issued.
- States: IDLE, LOAD, EXEC, WRITE, RESP. All outputs decoded from registered state plus latched op/imm.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_op/req_imm.
  - Legal op goes to LOAD. Illegal op (13-15) goes directly to RESP with rsp_err=1; no datapath strobes.
- LOAD (1 cycle): ldA=ldB=1, isImmediate=latched imm.
- EXEC:
  - Length N cycles: MUL N=MUL_CYCLES; DIV/MOD N=DIV_CYCLES; all others N=1.
  - Counter loads N-1 on entry and decrements; go to WRITE when it reaches 0.
- WRITE (1 cycle): CMP asserts wrFlag=1, ldResult=0. All other ops assert ldResult=1, wrFlag=0.
- Strobe hold: isImmediate, op_en (bit=latched op) and aluSel are held constant from LOAD through WRITE inclusive. They are 0 in IDLE and RESP.
- RESP:
  - rsp_valid=1; rsp_err=0 for legal ops.
  - Hold until rsp_ready, then go to IDLE. rsp_valid&&rsp_ready in the same cycle completes it.
  - req_ready=0 outside IDLE, so a new request is never accepted in the RESP handshake cycle.
- Latency (acceptance edge = cycle 0):
  - LOAD is cycle 1; EXEC is cycles 2..N+1; WRITE is cycle N+2; rsp_valid first high in cycle N+3.
  - Illegal op: rsp_valid in cycle 1.
- Back-to-back: minimum spacing between acceptances is N+4 cycles when rsp_ready is held high.
- Request inputs are ignored outside IDLE.
- Parameters below 1 are unsupported.

Optional Feature:
Macro ALU_SEQ_PERF_CNT_EN.
- Defined:
  - perf_ops increments on each rsp_valid&&rsp_ready handshake, including errors.
  - perf_busy increments each cycle state!=IDLE.
  - Both reset to 0, are 32-bit and wrap modulo 2^32.
- Undefined: perf_ops and perf_busy are tied to 0 and no counter flops are built.

Test Plan:
- Reset held 3 cycles mid-DIV → next cycle state=IDLE, req_ready=1, rsp_valid=0, clr*=1 while rst=1, no ldResult pulse.
- ADD (op=0, imm=0), rsp_ready=1 → ldA/ldB in cycle 1, op_en=13'h0001 and aluSel=0 cycles 1-3, ldResult in cycle 3, rsp_valid in cycle 4, rsp_err=0.
- DIV (op=4) with DIV_CYCLES=8 → aluSel=2 and op_en=13'h0010 held cycles 1-10, ldResult in cycle 10, rsp_valid in cycle 11.
- CMP (op=2, imm=1) → isImmediate=1 cycles 1-3, wrFlag=1 in cycle 3, ldResult never asserted.
- op=14 → no ld*/wrFlag strobes, rsp_valid=1 and rsp_err=1 in cycle 1.
- MUL then ADD back-to-back, rsp_ready low for 5 cycles on MUL → rsp_valid held stable, req_ready=0 throughout, ADD accepted only after the MUL handshake; with ALU_SEQ_PERF_CNT_EN, perf_ops=2 at end.
